// File: rtl/tb_sequencer_pkg.sv
// Shared definitions for the vector sequencer: FSM states, LFSR and operand constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tb_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DRIVE = 3'd2,
    WAIT  = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5
  } state_e;

  localparam logic [31:0] LFSR_MASK    = 32'h80200003;
  localparam logic [31:0] OPB_XOR      = 32'hA5A5A5A5;
  localparam logic [31:0] LFSR_RST_VAL = 32'h00000001;
  localparam int          DEFAULT_LAT  = 2;
  localparam int          DEFAULT_CNTW = 16;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    lfsr_next = {1'b0, s[31:1]} ^ (s[0] ? LFSR_MASK : 32'h0);
  endfunction

endpackage

// File: rtl/tb_sequencer_lfsr32.sv
// 32-bit Galois LFSR with synchronous load and step enable.
// Latency: state_o reflects a load or step one cycle after load_i/en_i.
// Backpressure: none; en_i gates stepping, load_i has priority over en_i.
// Ports: clk, reset (async active-low), load_i, en_i, seed_i[31:0], state_o[31:0].
module lfsr32
  import tb_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        en_i,
  input  logic [31:0] seed_i,
  output logic [31:0] state_o
);

  logic [31:0] state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LFSR_RST_VAL;
    end else if (load_i) begin
      state_q <= seed_i;
    end else if (en_i) begin
      state_q <= lfsr_next(state_q);
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/tb_sequencer.sv
// Stimulus sequencer: drives LFSR operand pairs, waits LAT cycles, tallies pass/fail events.
// Latency: LAT+2 cycles per vector; o_done pulses the cycle after the last CHECK.
// Backpressure: none; i_start is only honoured in IDLE and is never queued.
// Ports: clk, reset (async active-low), i_start, i_num_vec, i_seed, i_event (bit 0 = pass),
//        o_dut_ia/o_dut_ib (operands), o_busy, o_done, o_pass_cnt, o_fail_cnt.
module tb_sequencer
  import tb_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LAT   = DEFAULT_LAT,
  parameter int CNTW  = DEFAULT_CNTW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [CNTW-1:0]  i_num_vec,
  input  logic [WIDTH-1:0] i_seed,
  input  logic [WIDTH-1:0] i_event,
  output logic [WIDTH-1:0] o_dut_ia,
  output logic [WIDTH-1:0] o_dut_ib,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNTW-1:0]  o_pass_cnt,
  output logic [CNTW-1:0]  o_fail_cnt
);

  state_e           state_q;
  logic [WIDTH-1:0] ia_q, ib_q, seed_q;
  logic [CNTW-1:0]  num_q, vec_q, pass_q, fail_q;
  logic [3:0]       wait_q;
  logic             busy_q, done_q;
  logic [31:0]      lfsr;

  // Only the pass flag of the checker result matters.
  logic unused_event_bits;
  assign unused_event_bits = ^i_event[WIDTH-1:1];

  lfsr32 u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load_i  (state_q == LOAD),
    .en_i    (state_q == DRIVE),
    .seed_i  (seed_q),
    .state_o (lfsr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ia_q    <= '0;
      ib_q    <= '0;
      seed_q  <= WIDTH'(LFSR_RST_VAL);
      num_q   <= '0;
      vec_q   <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      wait_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            num_q   <= i_num_vec;
            // An all-zero seed would lock the LFSR, so substitute 1.
            seed_q  <= (i_seed == '0) ? WIDTH'(LFSR_RST_VAL) : i_seed;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          pass_q <= '0;
          fail_q <= '0;
          vec_q  <= num_q;
          if (num_q == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= DRIVE;
          end
        end
        DRIVE: begin
          ia_q    <= lfsr;
          ib_q    <= {lfsr[15:0], lfsr[31:16]} ^ OPB_XOR;
          wait_q  <= 4'(LAT - 1);
          state_q <= WAIT;
        end
        WAIT: begin
          // Counter starts at LAT-1 and exits on zero, so WAIT spans LAT cycles.
          if (wait_q == 4'd0) begin
            state_q <= CHECK;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        CHECK: begin
          if (i_event[0]) begin
            pass_q <= pass_q + CNTW'(1);
          end else begin
            fail_q <= fail_q + CNTW'(1);
          end
          vec_q <= vec_q - CNTW'(1);
          if (vec_q == CNTW'(1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= DRIVE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_dut_ia   = ia_q;
  assign o_dut_ib   = ib_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_pass_cnt = pass_q;
  assign o_fail_cnt = fail_q;

endmodule

// File: tb/tb_tb_sequencer.sv
// Self-checking bench for tb_sequencer: randomized runs against a behavioural run model.
module tb_tb_sequencer;

  localparam int LAT = 2;
  localparam int P   = LAT + 2;  // cycles per vector

  logic        clk;
  logic        reset;
  logic        i_start;
  logic [15:0] i_num_vec;
  logic [31:0] i_seed;
  logic [31:0] i_event;
  logic [31:0] o_dut_ia, o_dut_ib;
  logic        o_busy, o_done;
  logic [15:0] o_pass_cnt, o_fail_cnt;

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_ia = 32'h0;  // model of the operand A the DUT should be holding
  logic [31:0] last_ib = 32'h0;

  tb_sequencer #(.WIDTH(32), .LAT(LAT), .CNTW(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_start    (i_start),
    .i_num_vec  (i_num_vec),
    .i_seed     (i_seed),
    .i_event    (i_event),
    .o_dut_ia   (o_dut_ia),
    .o_dut_ib   (o_dut_ib),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_pass_cnt (o_pass_cnt),
    .o_fail_cnt (o_fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR step: shift right, XOR mask when the dropped bit was 1.
  function automatic logic [31:0] ref_step(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s % 2 == 1) n = n ^ 32'h80200003;
    return n;
  endfunction

  function automatic logic [31:0] ref_opb(input logic [31:0] s);
    return ((s << 16) | (s >> 16)) ^ 32'hA5A5A5A5;
  endfunction

  function automatic logic [31:0] rnd_event(input bit pass_bit);
    logic [31:0] r;
    r = $urandom;
    r[0] = pass_bit;
    return r;
  endfunction

  // One complete run. ev_mode: 0 = all pass, 1 = random, 2 = only vector fail_idx fails.
  // poke=1 raises i_start during DRIVE/WAIT of the first vector.
  task automatic do_run(input string name, input int n, input logic [31:0] seed,
                        input int ev_mode, input int fail_idx, input bit poke);
    bit          good[$];
    logic [31:0] ea[$], eb[$];
    logic [31:0] s;
    int exp_pass = 0, exp_fail = 0;
    int done_at = -1, done_n = 0;
    int lim, k, ph;
    bit g;
    for (int v = 0; v < n; v++) begin
      g = (ev_mode == 0) ? 1'b1 : (ev_mode == 1) ? bit'($urandom_range(0, 1)) : (v != fail_idx);
      good.push_back(g);
      if (g) exp_pass++; else exp_fail++;
    end
    s = (seed == 32'h0) ? 32'h1 : seed;
    for (int v = 0; v < n; v++) begin
      ea.push_back(s);
      eb.push_back(ref_opb(s));
      s = ref_step(s);
    end

    @(negedge clk);
    i_start = 1'b1; i_num_vec = 16'(n); i_seed = seed;
    @(negedge clk);  // cycle 0: LOAD
    i_start = 1'b0; i_num_vec = 16'($urandom); i_seed = $urandom;
    checks++;
    if (o_busy !== 1'b1) begin
      failures++; $display("FAIL %s busy_after_start got=%b exp=1", name, o_busy);
    end

    lim = 1 + n * P + 4;
    for (int c = 0; c <= lim; c++) begin
      k  = (c >= 1) ? (c - 1) / P : 0;
      ph = (c >= 1) ? (c - 1) % P : 0;
      // Correct pass flag only in the CHECK cycle; its inverse elsewhere.
      if (c >= 1 && k < n) i_event = rnd_event((ph == P - 1) ? good[k] : !good[k]);
      else                 i_event = $urandom;
      i_start = (poke && c >= 1 && k == 0 && ph < P - 1) ? 1'b1 : 1'b0;

      if (o_done === 1'b1) begin
        done_n++;
        if (done_at < 0) done_at = c;
      end
      if (c >= 1 && k < n && ph >= 1) begin
        checks++;
        if (o_dut_ia !== ea[k] || o_dut_ib !== eb[k]) begin
          failures++;
          $display("FAIL %s operands vec=%0d cyc=%0d got=%h/%h exp=%h/%h",
                   name, k, c, o_dut_ia, o_dut_ib, ea[k], eb[k]);
        end
      end
      if (n > 0 && c == n * P) begin
        checks++;
        if (o_busy !== 1'b1) begin
          failures++; $display("FAIL %s busy_last_check got=%b exp=1", name, o_busy);
        end
      end
      if (c == 1 + n * P || c == lim) begin
        checks++;
        if (o_busy !== 1'b0) begin
          failures++; $display("FAIL %s busy_done cyc=%0d got=%b exp=0", name, c, o_busy);
        end
      end
      @(negedge clk);
    end
    i_start = 1'b0;

    checks++;
    if (done_n != 1 || done_at != 1 + n * P) begin
      failures++;
      $display("FAIL %s done_pulse count=%0d at=%0d exp count=1 at=%0d", name, done_n, done_at, 1 + n * P);
    end
    checks++;
    if (o_pass_cnt !== 16'(exp_pass) || o_fail_cnt !== 16'(exp_fail)) begin
      failures++;
      $display("FAIL %s counts got=%0d/%0d exp=%0d/%0d", name, o_pass_cnt, o_fail_cnt, exp_pass, exp_fail);
    end
    if (n > 0) begin
      last_ia = ea[n - 1];
      last_ib = eb[n - 1];
    end
    checks++;
    if (o_dut_ia !== last_ia || o_dut_ib !== last_ib) begin
      failures++;
      $display("FAIL %s operands_held got=%h/%h exp=%h/%h", name, o_dut_ia, o_dut_ib, last_ia, last_ib);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; i_start = 1'b0; i_num_vec = '0; i_seed = '0; i_event = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_dut_ia, o_dut_ib, o_busy, o_done, o_pass_cnt, o_fail_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_state got ia=%h ib=%h busy=%b done=%b p=%0d f=%0d exp all zero",
               o_dut_ia, o_dut_ib, o_busy, o_done, o_pass_cnt, o_fail_cnt);
    end
    reset = 1'b1;
    i_num_vec = 16'd5; i_seed = $urandom;
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (o_busy !== 1'b0 || o_done !== 1'b0) begin
        failures++; $display("FAIL reset_idle busy=%b done=%b exp 0/0", o_busy, o_done);
      end
    end
  endtask

  task automatic test_zero_vec();
    do_run("zero_vec", 0, $urandom, 0, 0, 1'b0);
  endtask

  task automatic test_basic();
    do_run("basic_seed1", 4, 32'h1, 0, 0, 1'b0);
  endtask

  task automatic test_one_fail();
    do_run("third_fails", 4, 32'h1, 2, 2, 1'b0);
  endtask

  task automatic test_seed_zero();
    do_run("seed_zero", 4, 32'h0, 2, 2, 1'b0);
  endtask

  task automatic test_ignore_start();
    do_run("start_ignored", 3, $urandom, 1, 0, 1'b1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      do_run("random", $urandom_range(1, 20), $urandom, 1, 0, 1'b0);
    end
  endtask

  task automatic test_reset_midrun();
    int bad = 0;
    @(negedge clk);
    i_start = 1'b1; i_num_vec = 16'd8; i_seed = $urandom;
    @(negedge clk);  // cycle 0: LOAD
    i_start = 1'b0;
    for (int c = 0; c < P + 2; c++) begin
      i_event = rnd_event(1'b1);
      @(negedge clk);
    end
    // Now in cycle P+2: second vector, first WAIT cycle; drop reset between edges.
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({o_dut_ia, o_dut_ib, o_busy, o_done, o_pass_cnt, o_fail_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_midrun got ia=%h ib=%h busy=%b done=%b p=%0d f=%0d exp all zero",
               o_dut_ia, o_dut_ib, o_busy, o_done, o_pass_cnt, o_fail_cnt);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    last_ia = 32'h0; last_ib = 32'h0;
    for (int c = 0; c < 8 * P + 4; c++) begin
      @(negedge clk);
      if (o_busy !== 1'b0 || o_done !== 1'b0 || o_pass_cnt !== 16'h0 || o_dut_ia !== 32'h0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL reset_release_idle active_cycles=%0d exp=0", bad);
    end
  endtask

  task automatic test_hold_start();
    int dn[$];
    logic [31:0] sd;
    sd = $urandom | 32'h1;
    i_event = 32'h1;
    @(negedge clk);
    i_start = 1'b1; i_num_vec = 16'd1; i_seed = sd;
    @(negedge clk);  // cycle 0: first LOAD
    // Restart period: LOAD + one vector + DONE + IDLE.
    for (int c = 0; c <= 3 * (P + 3); c++) begin
      if (o_done === 1'b1) dn.push_back(c);
      @(negedge clk);
    end
    i_start = 1'b0;
    repeat (2 * P + 6) @(negedge clk);
    checks++;
    if (dn.size() != 3) begin
      failures++; $display("FAIL hold_start pulses got=%0d exp=3", dn.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (dn[j] != 1 + P + j * (P + 3)) begin
          failures++; $display("FAIL hold_start done_at[%0d] got=%0d exp=%0d", j, dn[j], 1 + P + j * (P + 3));
        end
      end
    end
    last_ia = sd; last_ib = ref_opb(sd);
    checks++;
    if (o_pass_cnt !== 16'd1 || o_fail_cnt !== 16'd0 || o_dut_ia !== last_ia || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL hold_start final p=%0d f=%0d ia=%h busy=%b exp 1/0/%h/0",
               o_pass_cnt, o_fail_cnt, o_dut_ia, o_busy, last_ia);
    end
  endtask

  initial begin
    test_reset();
    test_zero_vec();
    test_basic();
    test_one_fail();
    test_seed_zero();
    test_ignore_start();
    test_reset_midrun();
    test_zero_vec();
    test_hold_start();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
